// File: rtl/qbus_pkg.sv
// Shared QBUS slave definitions: sequencer states, bus widths, default reply delay
// and the DATOB read-merge helper.
package qbus_pkg;

  localparam int DATA_W       = 16;
  localparam int ADDR_W       = 13;
  localparam int RPLY_DLY_DEF = 2;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    SEL,
    IGNORE,
    READ,
    WRITE,
    HOLD
  } state_e;

  // Byte writes merge the addressed DAL byte into the current register word.
  function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] dal,
                                                    input logic [DATA_W-1:0] rdata,
                                                    input logic              byte_wr,
                                                    input logic              odd);
    if (!byte_wr) begin
      return dal;
    end else if (odd) begin
      return {dal[15:8], rdata[7:0]};
    end else begin
      return {rdata[15:8], dal[7:0]};
    end
  endfunction

endpackage

// File: rtl/qbus_slave_seq_if.sv
// Bus bundle between the QBUS pin side, the slave sequencer and the internal
// register blocks. The slave modport is the sequencer's view.
interface qbus_slave_seq_if;
  import qbus_pkg::*;

  logic              bSYNC;
  logic              bDIN;
  logic              bDOUT;
  logic              bBS7;
  logic              bWTBT;
  logic [DATA_W-1:0] bDAL_in;
  logic [DATA_W-1:0] bDAL_out;
  logic              bDAL_oe;
  logic              bRPLY;
  logic [ADDR_W-1:0] iADDR;
  logic              iBS7;
  logic              iWTBT;
  logic              iADDR_MATCH;
  logic [DATA_W-1:0] iRDATA;
  logic [DATA_W-1:0] iWDATA;
  logic              iWRITE;

  modport slave (
    input  bSYNC, bDIN, bDOUT, bBS7, bWTBT, bDAL_in, iADDR_MATCH, iRDATA,
    output bDAL_out, bDAL_oe, bRPLY, iADDR, iBS7, iWTBT, iWDATA, iWRITE
  );

  modport master (
    output bSYNC, bDIN, bDOUT, bBS7, bWTBT, bDAL_in, iADDR_MATCH, iRDATA,
    input  bDAL_out, bDAL_oe, bRPLY, iADDR, iBS7, iWTBT, iWDATA, iWRITE
  );

endinterface

// File: rtl/qbus_slave_seq_rply_timer.sv
// Data-phase delay counter: cleared outside the data phase, counts up and
// saturates at DLY; done marks the cycle in which RPLY may be raised.
module rply_timer #(
  parameter int DLY = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  output logic first_o,
  output logic done_o
);

  localparam int            CW      = $clog2(DLY + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DLY);
  localparam logic [CW-1:0] DONE_AT = CW'(DLY - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      cnt_q <= '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // done is flagged one count early so RPLY registers at data-phase start + DLY.
  assign first_o = (cnt_q == '0);
  assign done_o  = (cnt_q >= DONE_AT);

endmodule

// File: rtl/qbus_slave_seq.sv
// QBUS slave cycle sequencer: latches the address phase, serves DATI/DATO/DATOB
// (byte writes as read-merge-write) and DATIO onto the internal register bus.
module qbus_slave_seq
  import qbus_pkg::*;
#(
  parameter int RPLY_DLY = RPLY_DLY_DEF
) (
  input logic                   clk,
  input logic                   reset,
  qbus_slave_seq_if.slave       bus
);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              odd_q;
  logic              bs7_q;
  logic              wtbt_q;
  logic [DATA_W-1:0] dout_q;
  logic              oe_q;
  logic              rply_q;
  logic [DATA_W-1:0] wdata_q;
  logic              write_q;
  logic              tmr_first;
  logic              tmr_done;
  logic              tmr_clr;
  logic              strobe_act;

  assign tmr_clr = (state_q != READ) && (state_q != WRITE);

  rply_timer #(
    .DLY (RPLY_DLY)
  ) u_rply_timer (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (tmr_clr),
    .first_o (tmr_first),
    .done_o  (tmr_done)
  );

  // oe is only ever set by a read, so it tells HOLD which strobe to watch.
  assign strobe_act = oe_q ? bus.bDIN : bus.bDOUT;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      odd_q   <= 1'b0;
      bs7_q   <= 1'b0;
      wtbt_q  <= 1'b0;
      dout_q  <= '0;
      oe_q    <= 1'b0;
      rply_q  <= 1'b0;
      wdata_q <= '0;
      write_q <= 1'b0;
    end else begin
      write_q <= 1'b0;
      if (!bus.bSYNC) begin
        state_q <= IDLE;
        oe_q    <= 1'b0;
        rply_q  <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            addr_q  <= {bus.bDAL_in[ADDR_W-1:1], 1'b0};
            odd_q   <= bus.bDAL_in[0];
            bs7_q   <= bus.bBS7;
            wtbt_q  <= bus.bWTBT;
            state_q <= ADDR;
          end
          ADDR: begin
            state_q <= bus.iADDR_MATCH ? SEL : IGNORE;
          end
          IGNORE: begin
            state_q <= IGNORE;
          end
          SEL: begin
            if (bus.bDIN) begin
              state_q <= READ;
            end else if (bus.bDOUT) begin
              state_q <= WRITE;
            end
          end
          READ: begin
            oe_q   <= 1'b1;
            dout_q <= bus.iRDATA;
            if (tmr_done) begin
              rply_q  <= 1'b1;
              state_q <= HOLD;
            end
          end
          WRITE: begin
            if (tmr_first) begin
              wdata_q <= byte_merge(bus.bDAL_in, bus.iRDATA, bus.bWTBT, odd_q);
              write_q <= 1'b1;
            end
            if (tmr_done) begin
              rply_q  <= 1'b1;
              state_q <= HOLD;
            end
          end
          HOLD: begin
            if (!strobe_act) begin
              rply_q  <= 1'b0;
              oe_q    <= 1'b0;
              state_q <= SEL;
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.iADDR    = addr_q;
  assign bus.iBS7     = bs7_q;
  assign bus.iWTBT    = wtbt_q;
  assign bus.bDAL_out = dout_q;
  assign bus.bDAL_oe  = oe_q;
  assign bus.bRPLY    = rply_q;
  assign bus.iWDATA   = wdata_q;
  assign bus.iWRITE   = write_q;

endmodule

// File: tb/tb_qbus_slave_seq.sv
// Randomized QBUS master + register-block environment for qbus_slave_seq, with a
// word-level register model predicting read data, merged write data and timing.
module tb_qbus_slave_seq;
  import qbus_pkg::*;

  localparam int RPLY_DLY = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  qbus_slave_seq_if bus();

  qbus_slave_seq #(
    .RPLY_DLY (RPLY_DLY)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Register block: claims the upper half of the 8 KB space.
  logic [15:0] blk_mem   [0:4095];
  logic [15:0] model_mem [0:4095];
  int n_tests = 0;
  int n_fail  = 0;
  int wr_cnt  = 0;

  assign bus.iADDR_MATCH = bus.iADDR[12];
  assign bus.iRDATA      = blk_mem[bus.iADDR[12:1]];

  always @(negedge clk) begin
    if (bus.iWRITE) wr_cnt <= wr_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic addr_phase(input logic [15:0] a, input logic bs7, input logic wtbt);
    bus.bSYNC   = 1'b1;
    bus.bDAL_in = a;
    bus.bBS7    = bs7;
    bus.bWTBT   = wtbt;
    @(negedge clk);
    chk("iADDR", 32'(bus.iADDR), 32'({a[12:1], 1'b0}));
    chk("iBS7", 32'(bus.iBS7), 32'(bs7));
    chk("iWTBT", 32'(bus.iWTBT), 32'(wtbt));
    bus.bBS7    = 1'b0;
    bus.bWTBT   = 1'b0;
    bus.bDAL_in = 16'($urandom);
    @(negedge clk);
    chk("addr_rply", 32'(bus.bRPLY), 32'd0);
    chk("addr_oe", 32'(bus.bDAL_oe), 32'd0);
  endtask

  // One DATI or DATO(B) data phase, timed from the edge d that samples the strobe.
  task automatic data_phase(input logic is_wr, input logic byte_wr, input logic [15:0] data,
                            input logic matched, input logic odd, input logic [11:0] idx);
    logic [15:0] exp_rd;
    logic [15:0] exp_wd;
    int          w0;
    int          hold;
    logic        e_oe, e_rply, e_wr;
    exp_rd = model_mem[idx];
    if (!byte_wr)  exp_wd = data;
    else if (odd)  exp_wd = (data & 16'hFF00) | (exp_rd & 16'h00FF);
    else           exp_wd = (exp_rd & 16'hFF00) | (data & 16'h00FF);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    w0   = wr_cnt;
    hold = $urandom_range(0, 2);
    if (is_wr) begin
      bus.bDAL_in = data;
      bus.bWTBT   = byte_wr;
      bus.bDOUT   = 1'b1;
    end else begin
      bus.bDIN = 1'b1;
    end
    for (int k = 0; k <= RPLY_DLY + hold; k++) begin
      @(negedge clk);
      e_oe   = matched && !is_wr && (k >= 1);
      e_rply = matched && (k >= RPLY_DLY);
      e_wr   = matched && is_wr && (k == 1);
      chk("oe", 32'(bus.bDAL_oe), 32'(e_oe));
      chk("rply", 32'(bus.bRPLY), 32'(e_rply));
      chk("iwrite", 32'(bus.iWRITE), 32'(e_wr));
      if (e_oe) chk("rdata", 32'(bus.bDAL_out), 32'(exp_rd));
      if (e_wr) chk("wdata", 32'(bus.iWDATA), 32'(exp_wd));
      if (bus.iWRITE) blk_mem[bus.iADDR[12:1]] = bus.iWDATA;
    end
    if (matched && is_wr) model_mem[idx] = exp_wd;
    bus.bDIN  = 1'b0;
    bus.bDOUT = 1'b0;
    bus.bWTBT = 1'b0;
    @(negedge clk);
    chk("drop_rply", 32'(bus.bRPLY), 32'd0);
    chk("drop_oe", 32'(bus.bDAL_oe), 32'd0);
    chk("wr_pulses", 32'(wr_cnt - w0), 32'(matched && is_wr));
  endtask

  task automatic end_sync();
    bus.bSYNC = 1'b0;
    @(negedge clk);
    chk("idle_rply", 32'(bus.bRPLY), 32'd0);
    chk("idle_oe", 32'(bus.bDAL_oe), 32'd0);
    chk("idle_iwrite", 32'(bus.iWRITE), 32'd0);
  endtask

  // Abandon a write after the data phase starts but before the write strobe.
  task automatic abort_write(input logic by_reset);
    int w0;
    addr_phase(16'o17010, 1'b1, 1'b0);
    w0 = wr_cnt;
    bus.bDAL_in = 16'h5A5A;
    bus.bDOUT   = 1'b1;
    @(negedge clk);
    if (by_reset) reset = 1'b1;
    else          bus.bSYNC = 1'b0;
    @(negedge clk);
    chk("abort_iwrite", 32'(bus.iWRITE), 32'd0);
    chk("abort_rply", 32'(bus.bRPLY), 32'd0);
    chk("abort_oe", 32'(bus.bDAL_oe), 32'd0);
    if (by_reset) begin
      chk("rst_iaddr", 32'(bus.iADDR), 32'd0);
      chk("rst_iwdata", 32'(bus.iWDATA), 32'd0);
      chk("rst_dout", 32'(bus.bDAL_out), 32'd0);
      chk("rst_ibs7", 32'(bus.iBS7), 32'd0);
    end
    reset     = 1'b0;
    bus.bSYNC = 1'b0;
    bus.bDOUT = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_no_wr", 32'(wr_cnt - w0), 32'd0);
  endtask

  task automatic txn(input logic [15:0] a, input logic bs7, input int kind,
                     input logic [15:0] data, input logic byte_wr);
    addr_phase(a, bs7, byte_wr);
    if (kind == 0 || kind == 3) data_phase(1'b0, 1'b0, data, a[12], a[0], a[12:1]);
    if (kind == 1) data_phase(1'b1, 1'b0, data, a[12], a[0], a[12:1]);
    if (kind == 2 || kind == 3) data_phase(1'b1, byte_wr, data, a[12], a[0], a[12:1]);
    end_sync();
  endtask

  initial begin
    logic [15:0] v;
    logic [15:0] ra;
    for (int i = 0; i < 4096; i++) begin
      v            = 16'($urandom);
      blk_mem[i]   = v;
      model_mem[i] = v;
    end
    reset       = 1'b1;
    bus.bSYNC   = 1'b0;
    bus.bDIN    = 1'b0;
    bus.bDOUT   = 1'b0;
    bus.bBS7    = 1'b0;
    bus.bWTBT   = 1'b0;
    bus.bDAL_in = 16'h0;
    repeat (3) @(negedge clk);
    chk("rst_state_rply", 32'(bus.bRPLY), 32'd0);
    chk("rst_state_oe", 32'(bus.bDAL_oe), 32'd0);
    chk("rst_state_iwrite", 32'(bus.iWRITE), 32'd0);
    chk("rst_state_iaddr", 32'(bus.iADDR), 32'd0);
    chk("rst_state_iwdata", 32'(bus.iWDATA), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Word read of 0o17772 with BS7
    blk_mem[12'o7775]   = 16'o123456;
    model_mem[12'o7775] = 16'o123456;
    txn(16'o17772, 1'b1, 0, 16'h0, 1'b0);
    // Word write, then odd byte write over a known word
    txn(16'o17000, 1'b0, 1, 16'o054321, 1'b0);
    chk("word_wdata", 32'(bus.iWDATA), 32'(16'o054321));
    blk_mem[12'o7400]   = 16'h1234;
    model_mem[12'o7400] = 16'h1234;
    txn(16'o17001, 1'b0, 2, 16'hAB00, 1'b1);
    chk("odd_byte_wdata", 32'(bus.iWDATA), 32'hAB34);
    // Even byte write, unmatched access, DATIO
    txn(16'o17000, 1'b0, 2, 16'h00CD, 1'b1);
    chk("even_byte_wdata", 32'(bus.iWDATA), 32'hABCD);
    txn(16'o07772, 1'b1, 3, 16'h7777, 1'b0);
    txn(16'o17004, 1'b0, 3, 16'hBEEF, 1'b0);
    // Cancelled writes
    abort_write(1'b0);
    abort_write(1'b1);

    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      txn(ra, 1'($urandom), int'($urandom_range(0, 3)), 16'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
